// File: rtl/itlb_sv32.sv
`default_nettype none
// ============================================================================
// Module   : itlb_sv32
// Purpose  : Fully associative Sv32 instruction TLB with superpages, ASID/global
//            matching, sfence.vma selective flush and a page-table-walker port.
// Revision : 1.0  initial release
// ============================================================================
module itlb_sv32 #(
  parameter int NUM_ENTRY = 8,
  parameter int ASID_WD   = 9,
  parameter int PA_WD     = 34
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lk_valid,
  output logic               lk_ready,
  input  logic [31:0]        lk_vaddr,
  input  logic [ASID_WD-1:0] lk_asid,
  input  logic               lk_priv_u,
  output logic               resp_valid,
  output logic [PA_WD-1:0]   resp_paddr,
  output logic               resp_fault,
  output logic               ptw_req_valid,
  input  logic               ptw_req_ready,
  output logic [19:0]        ptw_req_vpn,
  output logic [ASID_WD-1:0] ptw_req_asid,
  input  logic               ptw_resp_valid,
  input  logic [31:0]        ptw_resp_pte,
  input  logic               ptw_resp_super,
  input  logic               ptw_resp_err,
  input  logic               flush_valid,
  input  logic               flush_vaddr_en,
  input  logic [31:0]        flush_vaddr,
  input  logic               flush_asid_en,
  input  logic [ASID_WD-1:0] flush_asid,
  output logic               busy
);

  localparam int IDX_WD = $clog2(NUM_ENTRY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [NUM_ENTRY-1:0] valid_q, valid_d;
  logic [NUM_ENTRY-1:0] super_q, super_d;
  logic [NUM_ENTRY-1:0] g_q, g_d;
  logic [NUM_ENTRY-1:0] u_q, u_d;
  logic [NUM_ENTRY-1:0] a_q, a_d;
  logic [NUM_ENTRY-1:0] x_q, x_d;
  logic [9:0]           vpn1_q [NUM_ENTRY];
  logic [9:0]           vpn1_d [NUM_ENTRY];
  logic [9:0]           vpn0_q [NUM_ENTRY];
  logic [9:0]           vpn0_d [NUM_ENTRY];
  logic [11:0]          ppn1_q [NUM_ENTRY];
  logic [11:0]          ppn1_d [NUM_ENTRY];
  logic [9:0]           ppn0_q [NUM_ENTRY];
  logic [9:0]           ppn0_d [NUM_ENTRY];
  logic [ASID_WD-1:0]   asid_q [NUM_ENTRY];
  logic [ASID_WD-1:0]   asid_d [NUM_ENTRY];

  logic [IDX_WD-1:0]    rr_q, rr_d;
  logic [31:0]          va_q, va_d;
  logic [ASID_WD-1:0]   wasid_q, wasid_d;
  logic                 priv_q, priv_d;
  logic                 drop_q, drop_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_fault_q, resp_fault_d;
  logic [PA_WD-1:0]     resp_paddr_q, resp_paddr_d;

  logic [NUM_ENTRY-1:0] hit_vec;
  logic [NUM_ENTRY-1:0] flush_hit;
  logic                 hit_any;
  logic [IDX_WD-1:0]    hit_idx;
  logic                 inv_any;
  logic [IDX_WD-1:0]    inv_idx;
  logic [IDX_WD-1:0]    victim;
  logic                 fill_en;
  logic                 lk_fire;
  logic                 hit_fault;
  logic [PA_WD-1:0]     hit_paddr;
  logic                 walk_fault;
  logic [PA_WD-1:0]     walk_paddr;
  logic                 unused_bits;

  assign unused_bits = ^{flush_vaddr[11:0], ptw_resp_pte[9:7]};

  generate
    for (genvar gi = 0; gi < NUM_ENTRY; gi++) begin : g_entry
      logic fva_match;
      logic fasid_match;
      assign hit_vec[gi] = valid_q[gi] && (vpn1_q[gi] == lk_vaddr[31:22]) &&
                           (super_q[gi] || (vpn0_q[gi] == lk_vaddr[21:12])) &&
                           (g_q[gi] || (asid_q[gi] == lk_asid));
      assign fva_match   = (vpn1_q[gi] == flush_vaddr[31:22]) &&
                           (super_q[gi] || (vpn0_q[gi] == flush_vaddr[21:12]));
      assign fasid_match = !g_q[gi] && (asid_q[gi] == flush_asid);
      // A disabled qualifier matches everything, so no qualifiers flushes all.
      assign flush_hit[gi] = flush_valid && (flush_vaddr_en ? fva_match : 1'b1) &&
                             (flush_asid_en ? fasid_match : 1'b1);
    end
  endgenerate

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_WD'(i);
      end
    end
  end

  always_comb begin
    inv_any = 1'b0;
    inv_idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        inv_any = 1'b1;
        inv_idx = IDX_WD'(i);
      end
    end
  end

  assign victim    = inv_any ? inv_idx : rr_q;
  assign lk_ready  = (state_q == S_IDLE) && !flush_valid;
  assign lk_fire   = lk_valid && lk_ready;
  assign hit_fault = (u_q[hit_idx] != lk_priv_u) || !x_q[hit_idx] || !a_q[hit_idx];
  assign hit_paddr = {ppn1_q[hit_idx],
                      super_q[hit_idx] ? lk_vaddr[21:12] : ppn0_q[hit_idx],
                      lk_vaddr[11:0]};

  assign walk_fault = ptw_resp_err || !ptw_resp_pte[0] || !ptw_resp_pte[3] ||
                      (ptw_resp_pte[2] && !ptw_resp_pte[1]) || !ptw_resp_pte[6] ||
                      (ptw_resp_pte[4] != priv_q) ||
                      (ptw_resp_super && (ptw_resp_pte[19:10] != 10'd0));
  assign walk_paddr = {ptw_resp_pte[31:20],
                       ptw_resp_super ? va_q[21:12] : ptw_resp_pte[19:10],
                       va_q[11:0]};

  always_comb begin
    state_d      = state_q;
    va_d         = va_q;
    wasid_d      = wasid_q;
    priv_d       = priv_q;
    drop_d       = drop_q;
    rr_d         = rr_q;
    fill_en      = 1'b0;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_paddr_d = resp_paddr_q;
    case (state_q)
      S_IDLE: begin
        if (lk_fire) begin
          if (hit_any) begin
            resp_valid_d = 1'b1;
            resp_fault_d = hit_fault;
            resp_paddr_d = hit_fault ? '0 : hit_paddr;
          end else begin
            va_d    = lk_vaddr;
            wasid_d = lk_asid;
            priv_d  = lk_priv_u;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush_valid) drop_d = 1'b1;
        if (ptw_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush_valid) drop_d = 1'b1;
        if (ptw_resp_valid) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = walk_fault;
          resp_paddr_d = walk_fault ? '0 : walk_paddr;
          // A flush landing with the walk result still kills the fill.
          fill_en      = !walk_fault && !drop_q && !flush_valid;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        drop_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (fill_en && !inv_any) rr_d = rr_q + 1'b1;
  end

  always_comb begin
    valid_d = valid_q & ~flush_hit;
    super_d = super_q;
    g_d     = g_q;
    u_d     = u_q;
    a_d     = a_q;
    x_d     = x_q;
    vpn1_d  = vpn1_q;
    vpn0_d  = vpn0_q;
    ppn1_d  = ppn1_q;
    ppn0_d  = ppn0_q;
    asid_d  = asid_q;
    if (fill_en) begin
      valid_d[victim] = 1'b1;
      super_d[victim] = ptw_resp_super;
      g_d[victim]     = ptw_resp_pte[5];
      u_d[victim]     = ptw_resp_pte[4];
      a_d[victim]     = ptw_resp_pte[6];
      x_d[victim]     = ptw_resp_pte[3];
      vpn1_d[victim]  = va_q[31:22];
      vpn0_d[victim]  = va_q[21:12];
      ppn1_d[victim]  = ptw_resp_pte[31:20];
      ppn0_d[victim]  = ptw_resp_pte[19:10];
      asid_d[victim]  = wasid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      super_q      <= '0;
      g_q          <= '0;
      u_q          <= '0;
      a_q          <= '0;
      x_q          <= '0;
      vpn1_q       <= '{default: '0};
      vpn0_q       <= '{default: '0};
      ppn1_q       <= '{default: '0};
      ppn0_q       <= '{default: '0};
      asid_q       <= '{default: '0};
      rr_q         <= '0;
      va_q         <= '0;
      wasid_q      <= '0;
      priv_q       <= 1'b0;
      drop_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_paddr_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      super_q      <= super_d;
      g_q          <= g_d;
      u_q          <= u_d;
      a_q          <= a_d;
      x_q          <= x_d;
      vpn1_q       <= vpn1_d;
      vpn0_q       <= vpn0_d;
      ppn1_q       <= ppn1_d;
      ppn0_q       <= ppn0_d;
      asid_q       <= asid_d;
      rr_q         <= rr_d;
      va_q         <= va_d;
      wasid_q      <= wasid_d;
      priv_q       <= priv_d;
      drop_q       <= drop_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_paddr_q <= resp_paddr_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_fault    = resp_fault_q;
  assign resp_paddr    = resp_paddr_q;
  assign ptw_req_valid = (state_q == S_REQ);
  assign ptw_req_vpn   = va_q[31:12];
  assign ptw_req_asid  = wasid_q;
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_itlb_sv32.sv
`default_nettype none
// ============================================================================
// Module   : tb_itlb_sv32
// Purpose  : Directed-vector self-checking bench for itlb_sv32.
// Revision : 1.0  initial release
// ============================================================================
module tb_itlb_sv32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lk_valid = 1'b0;
  logic        lk_ready;
  logic [31:0] lk_vaddr = '0;
  logic [8:0]  lk_asid = '0;
  logic        lk_priv_u = 1'b0;
  logic        resp_valid;
  logic [33:0] resp_paddr;
  logic        resp_fault;
  logic        ptw_req_valid;
  logic        ptw_req_ready = 1'b0;
  logic [19:0] ptw_req_vpn;
  logic [8:0]  ptw_req_asid;
  logic        ptw_resp_valid = 1'b0;
  logic [31:0] ptw_resp_pte = '0;
  logic        ptw_resp_super = 1'b0;
  logic        ptw_resp_err = 1'b0;
  logic        flush_valid = 1'b0;
  logic        flush_vaddr_en = 1'b0;
  logic [31:0] flush_vaddr = '0;
  logic        flush_asid_en = 1'b0;
  logic [8:0]  flush_asid = '0;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  itlb_sv32 #(.NUM_ENTRY(8), .ASID_WD(9), .PA_WD(34)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_vaddr(lk_vaddr),
    .lk_asid(lk_asid), .lk_priv_u(lk_priv_u),
    .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_fault(resp_fault),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
    .ptw_req_vpn(ptw_req_vpn), .ptw_req_asid(ptw_req_asid),
    .ptw_resp_valid(ptw_resp_valid), .ptw_resp_pte(ptw_resp_pte),
    .ptw_resp_super(ptw_resp_super), .ptw_resp_err(ptw_resp_err),
    .flush_valid(flush_valid), .flush_vaddr_en(flush_vaddr_en),
    .flush_vaddr(flush_vaddr), .flush_asid_en(flush_asid_en),
    .flush_asid(flush_asid), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_pte(input logic [21:0] ppn, input logic [7:0] fl);
    return {ppn, 2'b00, fl};
  endfunction

  // One lookup; services a walk with the given PTE if the DUT asks for one.
  task automatic xlate(input string tag, input logic [31:0] va, input logic [8:0] asid,
                       input logic pu, input logic exp_hit, input logic [31:0] pte,
                       input logic sup, input logic err, input logic flush_mid,
                       input logic exp_fault, input logic [33:0] exp_pa);
    @(negedge clk);
    chk({tag, ".rdy"}, lk_ready, 1);
    lk_valid = 1'b1; lk_vaddr = va; lk_asid = asid; lk_priv_u = pu;
    @(negedge clk);
    lk_valid = 1'b0;
    chk({tag, ".miss"}, ptw_req_valid, !exp_hit);
    if (ptw_req_valid) begin
      chk({tag, ".vpn"}, ptw_req_vpn, va[31:12]);
      chk({tag, ".asid"}, ptw_req_asid, asid);
      @(negedge clk);
      chk({tag, ".hold"}, ptw_req_valid, 1);
      ptw_req_ready = 1'b1;
      @(negedge clk);
      ptw_req_ready = 1'b0;
      chk({tag, ".wait_busy"}, busy, 1);
      chk({tag, ".wait_rdy"}, lk_ready, 0);
      if (flush_mid) begin
        flush_valid = 1'b1; flush_vaddr_en = 1'b1; flush_vaddr = 32'hFFFF_F000;
        @(negedge clk);
        flush_valid = 1'b0; flush_vaddr_en = 1'b0;
      end
      ptw_resp_valid = 1'b1; ptw_resp_pte = pte; ptw_resp_super = sup; ptw_resp_err = err;
      @(negedge clk);
      ptw_resp_valid = 1'b0; ptw_resp_super = 1'b0; ptw_resp_err = 1'b0;
    end
    chk({tag, ".rv"}, resp_valid, 1);
    chk({tag, ".fault"}, resp_fault, exp_fault);
    chk({tag, ".pa"}, resp_paddr, exp_pa);
    @(negedge clk);
    chk({tag, ".rv_end"}, resp_valid, 0);
    chk({tag, ".idle"}, busy, 0);
  endtask

  task automatic flush(input logic va_en, input logic [31:0] va,
                       input logic as_en, input logic [8:0] as);
    @(negedge clk);
    flush_valid = 1'b1; flush_vaddr_en = va_en; flush_vaddr = va;
    flush_asid_en = as_en; flush_asid = as;
    lk_valid = 1'b1;
    #1;
    chk("flush.rdy", lk_ready, 0);
    @(negedge clk);
    flush_valid = 1'b0; flush_vaddr_en = 1'b0; flush_asid_en = 1'b0; lk_valid = 1'b0;
    chk("flush.noresp", resp_valid, 0);
    chk("flush.nowalk", busy, 0);
  endtask

  task automatic rep(input int i, input logic exp_hit);
    logic [31:0] va;
    logic [33:0] pa;
    va = (32'h100 + i) << 12;
    pa = 34'((32'h200 + i) << 12);
    xlate($sformatf("rep%0d", i), va, 9'd1, 1'b0, exp_hit,
          mk_pte(22'(32'h200 + i), 8'h4B), 1'b0, 1'b0, 1'b0, 1'b0, pa);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.rdy", lk_ready, 1);
    chk("rst.rv", resp_valid, 0);
    chk("rst.fault", resp_fault, 0);
    chk("rst.pa", resp_paddr, 0);
    chk("rst.req", ptw_req_valid, 0);
    chk("rst.busy", busy, 0);
    rst_n = 1'b1;

    // Cold miss, repeat hit, U-mode fetch of an S page
    xlate("cold", 32'h0040_1123, 9'd5, 0, 0, mk_pte(22'h12345, 8'h4B), 0, 0, 0, 0, 34'h1234_5123);
    xlate("rehit", 32'h0040_1123, 9'd5, 0, 1, '0, 0, 0, 0, 0, 34'h1234_5123);
    xlate("ufetch", 32'h0040_1123, 9'd5, 1, 1, '0, 0, 0, 0, 1, 34'h0);

    // ASID miss, global refill, ASID flush leaves global entry
    xlate("asid6", 32'h0040_1123, 9'd6, 0, 0, mk_pte(22'h00777, 8'h6B), 0, 0, 0, 0, 34'h0077_7123);
    flush(0, 32'h0, 1, 9'd6);
    xlate("glob7", 32'h0040_1123, 9'd7, 0, 1, '0, 0, 0, 0, 0, 34'h0077_7123);

    // Address flush hits global too; then walk faults never fill
    flush(1, 32'h0040_1000, 0, 9'd0);
    xlate("f_x0", 32'h0040_1123, 9'd7, 0, 0, mk_pte(22'h00ABC, 8'h43), 0, 0, 0, 1, 34'h0);
    xlate("f_a0", 32'h0040_1123, 9'd7, 0, 0, mk_pte(22'h00ABC, 8'h0B), 0, 0, 0, 1, 34'h0);
    xlate("f_u1", 32'h0040_1123, 9'd7, 0, 0, mk_pte(22'h00ABC, 8'h5B), 0, 0, 0, 1, 34'h0);
    xlate("f_wr", 32'h0040_1123, 9'd7, 0, 0, mk_pte(22'h00ABC, 8'h4D), 0, 0, 0, 1, 34'h0);
    xlate("f_v0", 32'h0040_1123, 9'd7, 0, 0, mk_pte(22'h00ABC, 8'h4A), 0, 0, 0, 1, 34'h0);
    xlate("f_err", 32'h0040_1123, 9'd7, 0, 0, mk_pte(22'h00ABC, 8'h4B), 0, 1, 0, 1, 34'h0);
    xlate("f_ok", 32'h0040_1123, 9'd7, 0, 0, mk_pte(22'h00ABC, 8'h4B), 0, 0, 0, 0, 34'h00AB_C123);
    xlate("f_hit", 32'h0040_1123, 9'd7, 0, 1, '0, 0, 0, 0, 0, 34'h00AB_C123);

    // Superpages, including a misaligned one
    flush(0, 32'h0, 0, 9'd0);
    xlate("sp", 32'h0078_9ABC, 9'd1, 0, 0, mk_pte(22'h2AC00, 8'h4B), 1, 0, 0, 0, 34'h2AF8_9ABC);
    xlate("sp_hit", 32'h0040_0000, 9'd1, 0, 1, '0, 0, 0, 0, 0, 34'h2AC0_0000);
    xlate("sp_mis", 32'h00C0_0000, 9'd1, 0, 0, mk_pte(22'h2AC01, 8'h4B), 1, 0, 0, 1, 34'h0);
    xlate("sp_re", 32'h00C0_0010, 9'd1, 0, 0, mk_pte(22'h00400, 8'h4B), 1, 0, 0, 0, 34'h0040_0010);

    // Flush during a walk drops the fill but returns the result
    xlate("drop", 32'h0100_0456, 9'd1, 0, 0, mk_pte(22'h11111, 8'h4B), 0, 0, 1, 0, 34'h1111_1456);
    xlate("drop_re", 32'h0100_0456, 9'd1, 0, 0, mk_pte(22'h11111, 8'h4B), 0, 0, 0, 0, 34'h1111_1456);
    xlate("drop_hit", 32'h0100_0456, 9'd1, 0, 1, '0, 0, 0, 0, 0, 34'h1111_1456);

    // Replacement: 11 fills evict entries 0..2, pointer then at 3
    flush(0, 32'h0, 0, 9'd0);
    for (int i = 0; i < 11; i++) rep(i, 1'b0);
    for (int i = 3; i < 11; i++) rep(i, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) rep(0, 1'b0);   // refills entry 3, evicting vpn 3
    end
    rep(3, 1'b0);                 // entry 4, evicting vpn 4
    rep(5, 1'b1);
    rep(4, 1'b0);                 // entry 5
    for (int j = 0; j < 3; j++) rep(32'h200 + j, 1'b0);  // entries 6, 7, wrap to 0
    rep(10, 1'b1);
    rep(9, 1'b1);
    rep(8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/itlb_sv32.md
Name: itlb_sv32

Overview:
- Parametrised, fully associative instruction TLB for Sv32 translation. Generalises the single-entry itlb entry type to NUM_ENTRY entries.
- Adds features the entry type lacks: 4 MiB superpage entries, global/ASID matching, sfence.vma-style selective flush, permission and fault checking, and a miss handshake to the page-table walker.
- Sits between the fetch unit and the I-cache tag compare.
- Returns a physical address or a fault one cycle after a lookup hits, or after the walk response on a miss.

Parameters:
- NUM_ENTRY, 8, number of TLB entries; power of two, minimum 2.
- ASID_WD, 9, ASID width.
- PA_WD, 34, physical address width; fixed by Sv32 at 22-bit PPN plus 12-bit offset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lk_valid  in  1  lookup request
- lk_ready  out  1  lookup accepted when lk_valid&&lk_ready
- lk_vaddr  in  32  fetch virtual address
- lk_asid  in  ASID_WD  current satp.ASID
- lk_priv_u  in  1  1 = U-mode fetch, 0 = S-mode fetch
- resp_valid  out  1  one-cycle response pulse
- resp_paddr  out  PA_WD  translated address; valid when resp_valid && !resp_fault
- resp_fault  out  1  instruction page fault
- ptw_req_valid  out  1  walk request
- ptw_req_ready  in  1  walker accepts
- ptw_req_vpn  out  20  {vpn1,vpn0}
- ptw_req_asid  out  ASID_WD  ASID of the walk
- ptw_resp_valid  in  1  walk done, single-cycle pulse
- ptw_resp_pte  in  32  leaf PTE {ppn1,ppn0,rsw,D,A,G,U,X,W,R,V}
- ptw_resp_super  in  1  leaf found at level 1 (4 MiB)
- ptw_resp_err  in  1  walker access fault or non-leaf at level 0
- flush_valid  in  1  sfence.vma pulse
- flush_vaddr_en  in  1  rs1!=x0
- flush_vaddr  in  32  rs1 value
- flush_asid_en  in  1  rs2!=x0
- flush_asid  in  ASID_WD  rs2 value
- busy  out  1  FSM not IDLE

Behaviour:

Reset:
- All entry valid bits = 0; replacement pointer = 0; FSM = IDLE.
- resp_valid, resp_fault, ptw_req_valid, busy = 0; resp_paddr = 0.
- lk_ready = 1 after reset; it is combinationally gated off by flush_valid (see Flush).

Entry contents:
- valid, vpn1, vpn0, super, ppn1, ppn0, asid, G, U, A, X.

Hit:
- valid && vpn1==va[31:22] && (super || vpn0==va[21:12]) && (G || asid==lk_asid).
- At most one entry hits, because entries are filled only on a miss.

FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: lk_ready = !flush_valid.
  - Accepted lookup that hits: registered response next cycle, FSM stays IDLE, back-to-back lookups allowed.
  - Accepted lookup that misses: latch vaddr, asid and priv; go to REQ.
- REQ: ptw_req_valid=1, held stable until ptw_req_ready; then go to WAIT.
- WAIT: lk_ready=0; on ptw_resp_valid go to RESP.
- RESP: resp_valid=1 for one cycle, then go to IDLE.

Fill: on ptw_resp_valid, fill the victim unless the PTE faults or the walk is dropped.

Fault conditions (OR of):
- ptw_resp_err
- !V
- !X
- (W && !R)
- !A (A/D bits are software-managed)
- U != priv_u
- super && ppn0 != 0 (misaligned superpage)

A faulting PTE is not filled; resp_fault=1 and resp_paddr=0.

Hit-path check:
- Fault if entry U != lk_priv_u; the response carries resp_fault=1, paddr 0.
- X and A are guaranteed set by the fill rules.

Physical address:
- resp_paddr = {ppn1, super ? va[21:12] : ppn0, va[11:0]}.

Victim selection:
- Lowest-index invalid entry if one exists.
- Otherwise the entry at the round-robin pointer; the pointer increments on each fill into a valid entry and wraps NUM_ENTRY-1 → 0.

Flush (single cycle, takes effect on the clock edge):
- !vaddr_en && !asid_en: invalidate all entries.
- vaddr_en only: invalidate entries that hit flush_vaddr for any ASID, including G entries.
- asid_en only: invalidate non-G entries with asid == flush_asid.
- both: invalidate non-G entries that hit flush_vaddr with asid == flush_asid.
- A flush in the same cycle as lk_valid means the lookup is not accepted (lk_ready=0).
- A flush during REQ or WAIT sets a drop flag. The walk completes and the response is returned, but no fill occurs. The drop flag clears on return to IDLE.

Simultaneous events:
- A flush cycle coincident with ptw_resp_valid counts as during the walk: the result is dropped.

Reset mid-walk:
- The FSM returns to IDLE and all entries are invalidated.
- The walker is expected to be reset by the same rst_n.

Test Plan:
- Cold miss: lookup va=0x0040_1123, asid=5, S-mode. Expect ptw_req vpn=0x00401. Respond pte ppn=0x12345, A,X,R,V=1, G=0, U=0. Expect resp_paddr=0x1234_5123 and entry 0 filled. Repeat the lookup: hit, resp the following cycle, no ptw_req.
- Superpage: fill super=1, ppn1=0x0AB, ppn0=0 for vpn1=0x001. Lookup va=0x0078_9ABC. Expect hit with resp_paddr=0x2AF8_9ABC. A fill with ppn0=0x001 and super=1 instead gives resp_fault=1 and no fill.
- ASID/global: fill asid=5, G=0. Lookup with asid=6 misses. Refill the same VPN with G=1; then flush asid_en=1, asid=6; a lookup with asid=7 still hits.
- Flush during walk: miss, then a flush_valid pulse in WAIT, then ptw_resp. Expect a valid response but a subsequent lookup of the same VA misses again.
- Replacement: fill NUM_ENTRY=8 distinct VPNs, then 3 more. Expect entries 0,1,2 evicted in order; the pointer wraps after 8 further fills.
- Faults: PTE X=0, A=0, or U=1 for an S-mode fetch each give resp_fault=1 with no fill. A hit on a U=0 entry from lk_priv_u=1 gives resp_fault=1.
